// File: rtl/j11bus2_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package    : j11bus_pkg                                                |
// | Purpose    : Shared types and constants for the J11 bus controller:    |
// |              controller state encoding, general-purpose (GP) register  |
// |              addresses and the power-up status word.                   |
// | Ports      : none (package)                                            |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
package j11bus_pkg;

  // Controller states. DONE is the one-cycle acknowledge slot that follows
  // every accepted cycle before the controller listens to busreq again.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEM  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // GP cycle addresses (low byte of busaddr)
  localparam logic [7:0]  c_GPA_PWRUP  = 8'o0;    // power-up word read
  localparam logic [7:0]  c_GPA_RSTSET = 8'o14;   // write: assert busrst
  localparam logic [7:0]  c_GPA_RSTCLR = 8'o214;  // write: release busrst

  localparam logic [15:0] c_PWRUP_WORD = 16'o0005;

  // Read data returned for a GP cycle: only a read of the power-up
  // address returns something other than zero.
  function automatic logic [15:0] gp_rdata(input logic wr, input logic [7:0] addr);
    return (!wr && (addr == c_GPA_PWRUP)) ? c_PWRUP_WORD : 16'h0000;
  endfunction

endpackage
`default_nettype wire

// File: rtl/j11bus2_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface  : j11bus2_if                                                |
// | Purpose    : Bundles the J11 CPU-side cycle signals and the memory     |
// |              side request/completion signals of the bus controller.    |
// | Modports   : slave  - the controller (j11bus2)                         |
// |              master - the environment (CPU + memory)                   |
// | Signals    : busreq/buswr/busgp/busirq/busaddr/buswdata  CPU cycle     |
// |              busack/buserr/busrdata/busrst              CPU response   |
// |              memreq/memwr/memaddr/memwdata              memory request |
// |              memack/memerr/memrdata                     memory reply   |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
interface j11bus2_if;

  logic        busreq;
  logic        buswr;
  logic        busgp;
  logic        busirq;
  logic [21:0] busaddr;
  logic [15:0] buswdata;
  logic        busack;
  logic        buserr;
  logic [15:0] busrdata;
  logic        busrst;

  logic        memreq;
  logic        memwr;
  logic [21:0] memaddr;
  logic [15:0] memwdata;
  logic        memack;
  logic        memerr;
  logic [15:0] memrdata;

  modport slave (
    input  busreq, buswr, busgp, busirq, busaddr, buswdata,
    output busack, buserr, busrdata, busrst,
    output memreq, memwr, memaddr, memwdata,
    input  memack, memerr, memrdata
  );

  modport master (
    output busreq, buswr, busgp, busirq, busaddr, buswdata,
    input  busack, buserr, busrdata, busrst,
    input  memreq, memwr, memaddr, memwdata,
    output memack, memerr, memrdata
  );

endinterface
`default_nettype wire

// File: rtl/j11bus2_irqarb.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : j11irqarb                                                 |
// | Purpose    : Interrupt arbitration. Masks the pending channels by the  |
// |              requested level set and picks the lowest-index survivor.  |
// |              Also produces the per-level OR of pending channels.       |
// | Parameters : NIRQ   number of channels (1..16)                         |
// |              IRQLVL packed NIRQ x 2-bit level per channel              |
// | Ports      : i_pending [NIRQ] pending flags                            |
// |              i_lvlsel  [4]    one-hot level being acknowledged         |
// |              o_idx     [4]    winning channel index                    |
// |              o_valid          a winner exists                          |
// |              o_lvl_any [4]    OR of pending channels per level         |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module j11irqarb #(
  parameter int                NIRQ   = 4,
  parameter logic [2*NIRQ-1:0] IRQLVL = {2'd1, 2'd0, 2'd0, 2'd0}
) (
  input  wire logic [NIRQ-1:0] i_pending,
  input  wire logic [3:0]      i_lvlsel,
  output logic      [3:0]      o_idx,
  output logic                 o_valid,
  output logic      [3:0]      o_lvl_any
);

  logic [1:0]      w_lvl [NIRQ];
  logic [NIRQ-1:0] w_elig;

  for (genvar gi = 0; gi < NIRQ; gi++) begin : g_chan
    assign w_lvl[gi]  = IRQLVL[2*gi +: 2];
    assign w_elig[gi] = i_pending[gi] & i_lvlsel[w_lvl[gi]];
  end

  // Scan from the top down so the lowest eligible index is the last writer.
  always_comb begin
    o_valid = 1'b0;
    o_idx   = 4'd0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (w_elig[i]) begin
        o_valid = 1'b1;
        o_idx   = i[3:0];
      end
    end
  end

  always_comb begin
    o_lvl_any = 4'b0000;
    for (int i = 0; i < NIRQ; i++) begin
      if (i_pending[i]) begin
        o_lvl_any[w_lvl[i]] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/j11bus2.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module     : j11bus2                                                   |
// | Purpose    : J11 bus controller. Serves GP register cycles, interrupt  |
// |              acknowledge cycles and forwards all other cycles to       |
// |              memory. Latches interrupt pulses and drives the four      |
// |              J11 interrupt request levels.                             |
// | Options    : J11BUS_TIMEOUT_EN - when defined, a memory cycle with no  |
// |              memack for TMO clocks completes with buserr.              |
// | Parameters : NIRQ (1..16), IRQVEC, IRQLVL, TMO (1..65535)              |
// | Ports      : clk      rising-edge clock                                |
// |              rstn     asynchronous active-low reset                    |
// |              bus      j11bus2_if.slave, CPU and memory signals         |
// |              irq      [NIRQ] one-clock interrupt pulses                |
// |              j11irq   [4]    registered request levels                 |
// |              pending  [NIRQ] latched pending flags                     |
// | Revision   : 1.0  initial release                                      |
// +------------------------------------------------------------------------+
module j11bus2
  import j11bus_pkg::*;
#(
  parameter int                 NIRQ   = 4,
  parameter logic [16*NIRQ-1:0] IRQVEC = {16'o160, 16'o70, 16'o64, 16'o60},
  parameter logic [2*NIRQ-1:0]  IRQLVL = {2'd1, 2'd0, 2'd0, 2'd0},
  parameter int                 TMO    = 255
) (
  input  wire logic            clk,
  input  wire logic            rstn,
  j11bus2_if.slave             bus,
  input  wire logic [NIRQ-1:0] irq,
  output logic      [3:0]      j11irq,
  output logic      [NIRQ-1:0] pending
);

  state_t          r_state;
  logic            r_busack;
  logic            r_buserr;
  logic [15:0]     r_busrdata;
  logic            r_busrst;
  logic            r_memreq;
  logic [NIRQ-1:0] r_pending;
  logic [3:0]      r_j11irq;

  logic [3:0]      w_arb_idx;
  logic            w_arb_valid;
  logic [3:0]      w_lvl_any;
  logic [15:0]     w_irq_vec;
  logic [NIRQ-1:0] w_irq_clr;
  logic            w_iack_take;

  // ---------------------------------------------------------------------
  // Interrupt arbitration
  // ---------------------------------------------------------------------
  j11irqarb #(
    .NIRQ   (NIRQ),
    .IRQLVL (IRQLVL)
  ) u_arb (
    .i_pending (r_pending),
    .i_lvlsel  (bus.busaddr[3:0]),
    .o_idx     (w_arb_idx),
    .o_valid   (w_arb_valid),
    .o_lvl_any (w_lvl_any)
  );

  // An acknowledge that finds a winner clears exactly that channel.
  assign w_iack_take = (r_state == ST_IDLE) && bus.busreq && !bus.busgp &&
                       bus.busirq && w_arb_valid;

  always_comb begin
    w_irq_vec = 16'h0000;
    w_irq_clr = '0;
    for (int i = 0; i < NIRQ; i++) begin
      if (w_arb_idx == i[3:0]) begin
        w_irq_vec    = IRQVEC[16*i +: 16];
        w_irq_clr[i] = w_iack_take;
      end
    end
  end

  // Set has priority over clear for a channel pulsing during its own ack.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pending <= '0;
      r_j11irq  <= 4'b0000;
    end else begin
      r_pending <= (r_pending & ~w_irq_clr) | irq;
      r_j11irq  <= w_lvl_any;
    end
  end

  // ---------------------------------------------------------------------
  // Memory timeout counter
  // ---------------------------------------------------------------------
`ifdef J11BUS_TIMEOUT_EN
  localparam logic [15:0] c_TMO_LAST = 16'(TMO - 1);

  logic [15:0] r_tmo;
  logic        w_tmo_hit;

  // Counter holds the number of MEM cycles already spent; the cycle that
  // would bring it to TMO is the timeout, unless memack arrives then.
  assign w_tmo_hit = (r_state == ST_MEM) && !bus.memack && (r_tmo == c_TMO_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo <= 16'd0;
    end else if ((r_state == ST_MEM) && !bus.memack && !w_tmo_hit) begin
      r_tmo <= r_tmo + 16'd1;
    end else begin
      r_tmo <= 16'd0;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Controller
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= ST_IDLE;
      r_busack   <= 1'b0;
      r_buserr   <= 1'b0;
      r_busrdata <= 16'h0000;
      r_busrst   <= 1'b1;
      r_memreq   <= 1'b0;
    end else begin
      // ack, err and memreq are single-cycle pulses by default
      r_busack <= 1'b0;
      r_buserr <= 1'b0;
      r_memreq <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.busreq) begin
            if (bus.busgp) begin
              r_busrdata <= gp_rdata(bus.buswr, bus.busaddr[7:0]);
              if (bus.buswr && (bus.busaddr[7:0] == c_GPA_RSTSET)) begin
                r_busrst <= 1'b1;
              end else if (bus.buswr && (bus.busaddr[7:0] == c_GPA_RSTCLR)) begin
                r_busrst <= 1'b0;
              end
              r_busack <= 1'b1;
              r_state  <= ST_DONE;
            end else if (bus.busirq) begin
              // No pending channel at this level still acks, with a zero vector
              r_busrdata <= w_arb_valid ? w_irq_vec : 16'h0000;
              r_busack   <= 1'b1;
              r_state    <= ST_DONE;
            end else begin
              r_memreq <= 1'b1;
              r_state  <= ST_MEM;
            end
          end
        end

        ST_MEM: begin
          if (bus.memack) begin
            r_busack   <= 1'b1;
            r_buserr   <= bus.memerr;
            r_busrdata <= bus.memrdata;
            r_state    <= ST_DONE;
          end
`ifdef J11BUS_TIMEOUT_EN
          else if (w_tmo_hit) begin
            r_busack   <= 1'b1;
            r_buserr   <= 1'b1;
            r_busrdata <= 16'h0000;
            r_state    <= ST_DONE;
          end
`endif
        end

        // memack seen here (late or stray) is deliberately not examined
        ST_DONE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign bus.busack   = r_busack;
  assign bus.buserr   = r_buserr;
  assign bus.busrdata = r_busrdata;
  assign bus.busrst   = r_busrst;
  assign bus.memreq   = r_memreq;

  // Memory qualifiers pass straight through from the CPU side
  assign bus.memwr    = bus.buswr;
  assign bus.memaddr  = bus.busaddr;
  assign bus.memwdata = bus.buswdata;

  assign pending = r_pending;
  assign j11irq  = r_j11irq;

endmodule
`default_nettype wire

// File: doc/j11bus2.md
J11BUS2 -- requirements
Module: j11bus2

Interface
REQ-001 Parameter NIRQ, default 4: number of interrupt source channels, range 1..16.
REQ-002 Parameter IRQVEC, default {16'o160,16'o70,16'o64,16'o60}: packed NIRQ x 16-bit vector table; channel i occupies bits [16i+15:16i].
REQ-003 Parameter IRQLVL, default {2'd1,2'd0,2'd0,2'd0}: packed NIRQ x 2-bit level per channel, selecting j11irq bit 0..3.
REQ-004 Parameter TMO, default 255: memory timeout in clk cycles, range 1..65535.
REQ-005 clk  in  1  sole clock; all logic on its rising edge.
REQ-006 rstn  in  1  asynchronous active-low reset.
REQ-007 busreq, buswr, busgp, busirq  in  1 each  J11 cycle request, write, general-purpose cycle, interrupt-acknowledge cycle.
REQ-008 busaddr  in  22; buswdata  in  16  cycle address and write data.
REQ-009 busack, buserr  out  1 each; busrdata  out  16  cycle completion, error and read data.
REQ-010 busrst  out  1  bus reset.
REQ-011 memreq  out  1; memwr  out  1; memaddr  out  22; memwdata  out  16  memory request; memwr, memaddr and memwdata are combinational copies of buswr, busaddr and buswdata.
REQ-012 memack, memerr  in  1 each; memrdata  in  16  memory completion.
REQ-013 irq  in  NIRQ  per-channel interrupt pulses, each one clk wide.
REQ-014 j11irq  out  4  registered interrupt request level lines.
REQ-015 pending  out  NIRQ  latched pending flags, exposed for status.

Function
REQ-016 The controller SHALL be a state machine with states IDLE, MEM and DONE, and SHALL accept busreq only in IDLE.
REQ-017 In IDLE, a busreq with busgp SHALL move to DONE with busack one cycle later. busrdata SHALL be 16'o0005 for a GP read of address 8'o0. A GP write to 8'o14 SHALL set busrst; a write to 8'o214 SHALL clear it. Any other GP address SHALL be acknowledged with busrdata 0.
REQ-018 In IDLE, a busreq with busirq SHALL take the level one-hot from busaddr[3:0]. Among pending channels of that level, the lowest-index channel SHALL win: busrdata = its vector, its pending flag cleared, busack one cycle later. If no channel is pending at that level, busrdata SHALL be 0 with busack asserted and buserr low.
REQ-019 In IDLE, any other busreq SHALL pulse memreq for exactly one cycle and enter MEM.
REQ-020 In MEM, memack SHALL produce busack, busrdata = memrdata and buserr = memerr on the next cycle, then return to IDLE.
REQ-021 busack and buserr SHALL be single-cycle pulses; busrdata SHALL hold its value until the next acknowledge.
REQ-022 irq[i] SHALL set pending[i] on the following cycle. If set and clear occur in the same cycle, set SHALL win.
REQ-023 j11irq[k] SHALL equal, registered by one cycle, the OR of pending[i] over all channels whose level is k.
REQ-024 memack arriving in IDLE or DONE SHALL be ignored.

Reset
REQ-025 Asserting rstn low SHALL force state=IDLE, busack=0, buserr=0, busrdata=0, memreq=0, busrst=1, pending=0, j11irq=0 and timeout counter=0, including mid-transaction; a memack that later arrives from the abandoned cycle SHALL be ignored.

Configuration
REQ-026 With J11BUS_TIMEOUT_EN defined, a counter SHALL run in MEM. On reaching TMO without memack, the block SHALL pulse busack and buserr together with busrdata=0 and return to IDLE. If memack arrives on the same cycle the counter reaches TMO, memack SHALL win.
REQ-027 With J11BUS_TIMEOUT_EN undefined, no counter SHALL exist and MEM SHALL wait indefinitely for memack.

Structure
REQ-028 Package j11bus_pkg SHALL hold the state enum, GP address constants (8'o0, 8'o14, 8'o214) and the powerup word.
REQ-029 Sub-module j11irqarb SHALL implement per-level masking and the lowest-index priority encode for NIRQ channels, returning a winner index and a valid flag.

Verification
REQ-030 GP read of 8'o0 -> busack after 1 cycle, busrdata=16'o0005; GP write of 8'o214 -> busrst=0; GP write of 8'o14 -> busrst=1.
REQ-031 Pulse irq[0] and irq[1], then IACK with busaddr[3:0]=4'b0001 -> busrdata=16'o60 and pending[0] cleared; repeat -> busrdata=16'o64; j11irq[0] drops 1 cycle after the second acknowledge.
REQ-032 Memory read with memack 5 cycles after memreq and memrdata=16'hBEEF -> busack next cycle, busrdata=16'hBEEF, buserr=0; memerr=1 -> buserr=1.
REQ-033 With J11BUS_TIMEOUT_EN and TMO=8, no memack -> busack and buserr pulse 8 cycles after entry to MEM; memack on cycle 8 -> normal completion.
REQ-034 rstn low during MEM, late memack after release -> no busack; all outputs at reset values.
REQ-035 irq[2] pulsed on the same cycle as an acknowledge of channel 2 -> pending[2] remains 1.
